// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin front end sharing one fe_mulx
// between two requester ports with registered operands/results.
module fe_mul_arbiter #(
  parameter int W = 320
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] r0_op_a,
  input  logic [W-1:0] r0_op_b,
  input  logic         r0_valid,
  output logic [W-1:0] r0_res,
  output logic         r0_done,
  input  logic [W-1:0] r1_op_a,
  input  logic [W-1:0] r1_op_b,
  input  logic         r1_valid,
  output logic [W-1:0] r1_res,
  output logic         r1_done,
  output logic [W-1:0] m_op_a,
  output logic [W-1:0] m_op_b,
  output logic         m_valid,
  input  logic [W-1:0] m_res,
  input  logic         m_done,
  output logic         busy,
  output logic [1:0]   gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic         own_q, own_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] res0_q, res0_d;
  logic [W-1:0] res1_q, res1_d;
  logic [1:0]   done_q, done_d;
  logic [1:0]   gnt_q, gnt_d;
  logic         pick;

  // State and datapath registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      done_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      done_q  <= done_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for the product, then
  // spend one RESP cycle signalling done to the owner.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    done_d  = '0;
    gnt_d   = gnt_q;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          if (r0_valid && r1_valid) pick = ~last_q;
          else                      pick = r1_valid;
          own_d   = pick;
          last_d  = pick;
          opa_d   = pick ? r1_op_a : r0_op_a;
          opb_d   = pick ? r1_op_b : r0_op_b;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (m_done) begin
          if (own_q) res1_d = m_res;
          else       res0_d = m_res;
          done_d[own_q] = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign m_op_a  = opa_q;
  assign m_op_b  = opb_q;
  assign m_valid = (state_q == GRANT);
  assign busy    = (state_q != IDLE);
  assign gnt     = gnt_q;
  assign r0_res  = res0_q;
  assign r1_res  = res1_q;
  assign r0_done = done_q[0];
  assign r1_done = done_q[1];

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb_fe_mul_arbiter: directed + random stimulus against a
// transaction-level arbiter model and a behavioural multiplier.
module tb_fe_mul_arbiter;
  localparam int W = 320;

  logic         clk = 1'b0;
  logic         rst;
  logic         rv [2];
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [W-1:0] r0_res, r1_res;
  logic         r0_done, r1_done;
  logic [W-1:0] m_op_a, m_op_b, m_res;
  logic         m_valid, m_done, busy;
  logic [1:0]   gnt;

  fe_mul_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .r0_op_a(ra[0]), .r0_op_b(rb[0]), .r0_valid(rv[0]),
    .r0_res(r0_res), .r0_done(r0_done),
    .r1_op_a(ra[1]), .r1_op_b(rb[1]), .r1_valid(rv[1]),
    .r1_res(r1_res), .r1_done(r1_done),
    .m_op_a(m_op_a), .m_op_b(m_op_b), .m_valid(m_valid),
    .m_res(m_res), .m_done(m_done),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 idle, 1 multiplier owned, 2 done cycle
  int           ph, own, last, cyc;
  logic [W-1:0] ea [2];
  logic [W-1:0] eb [2];
  logic [W-1:0] eres [2];
  int           done_cnt [2];
  int           done_cyc [2];
  int           gq [$];
  // multiplier model
  bit           mx_on, spur;
  int           mx_cnt, mx_fix;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    ph = 0; last = 1; own = 0;
    eres[0] = '0; eres[1] = '0;
    mx_on = 0;
  endtask

  task automatic tick();
    logic v0, v1, md;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0] eg;
    v0 = rv[0]; v1 = rv[1]; md = m_done;
    a0 = ra[0]; b0 = rb[0]; a1 = ra[1]; b1 = rb[1];
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst) mdl_reset();
    else if (ph == 0) begin
      if (v0 || v1) begin
        if (v0 && v1) own = 1 - last;
        else          own = v0 ? 0 : 1;
        last = own;
        ea[own] = own ? a1 : a0;
        eb[own] = own ? b1 : b0;
        gq.push_back(own);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (md) begin
        ph = 2;
        eres[own] = ea[own] * eb[own];
        done_cnt[own]++;
        done_cyc[own] = cyc;
      end
    end else ph = 0;
    eg = (ph == 0) ? 2'b00 : (own ? 2'b10 : 2'b01);
    chk("gnt", gnt, eg);
    chk("busy", busy, ph != 0);
    chk("m_valid", m_valid, ph == 1);
    if (ph == 1) begin
      chk("m_op_a", m_op_a, ea[own]);
      chk("m_op_b", m_op_b, eb[own]);
    end
    if (!rst) begin
      chk("rst_op_a", m_op_a, '0);
      chk("rst_op_b", m_op_b, '0);
    end
    chk("r0_done", r0_done, ph == 2 && own == 0);
    chk("r1_done", r1_done, ph == 2 && own == 1);
    chk("r0_res", r0_res, eres[0]);
    chk("r1_res", r1_res, eres[1]);
    if (!rst || ph != 1) begin
      mx_on  = 0;
      m_done = spur;
      m_res  = spur ? W'('hdead) : W'($urandom);
      spur   = 0;
    end else begin
      if (!mx_on) begin
        mx_on  = 1;
        mx_cnt = mx_fix ? mx_fix : $urandom_range(1, 3);
      end
      if (mx_cnt == 1) begin
        m_done = 1;
        m_res  = m_op_a * m_op_b;
      end else begin
        m_done = 0;
        m_res  = W'($urandom);
      end
      mx_cnt--;
    end
  endtask

  task automatic wait_resp(input int p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(ph == 2 && own == p) && n < 40);
    chk("resp_timeout", n < 40, 1'b1);
  endtask

  task automatic new_op(input int p);
    ra[p] = W'($urandom);
    rb[p] = W'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    rv[0] = 0; rv[1] = 0;
    ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
    m_done = 0; m_res = '0;
    spur = 0; mx_fix = 0; cyc = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    mdl_reset();
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // single request, operand change after grant
    ra[0] = W'('h3); rb[0] = W'('h5); rv[0] = 1;
    tick();
    chk("single_gnt", gnt, 2'b01);
    chk("single_mv", m_valid, 1'b1);
    ra[0] = W'('h7);
    wait_resp(0);
    rv[0] = 0;
    chk("single_res", r0_res, W'('hf));
    tick();
    chk("single_idle_gnt", gnt, 2'b00);
    chk("single_idle_busy", busy, 1'b0);
    chk("single_cnt0", done_cnt[0], 1);
    chk("single_cnt1", done_cnt[1], 0);

    // simultaneous after reset
    rst = 1'b0; tick(); rst = 1'b1;
    gq.delete();
    ra[0] = W'('h2); rb[0] = W'('h7);
    ra[1] = W'('h4); rb[1] = W'('h9);
    rv[0] = 1; rv[1] = 1;
    wait_resp(0);
    rv[0] = 0;
    chk("sim_r0", r0_res, W'('he));
    wait_resp(1);
    rv[1] = 0;
    chk("sim_r1", r1_res, W'('h24));
    chk("sim_first", gq[0], 0);
    chk("sim_second", gq[1], 1);
    chk("sim_gap", (done_cyc[1] - done_cyc[0]) >= 3, 1'b1);
    tick();

    // fairness: both held across four operations
    gq.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    new_op(0); new_op(1);
    rv[0] = 1; rv[1] = 1;
    for (int k = 0; k < 4; k++) begin
      wait_resp(k % 2);
      new_op(own);
    end
    rv[0] = 0; rv[1] = 0;
    tick(); tick();
    for (int k = 0; k < 4; k++) chk("fair_order", gq[k], k % 2);
    chk("fair_cnt0", done_cnt[0], 2);
    chk("fair_cnt1", done_cnt[1], 2);

    // reset in the middle of an operation
    mx_fix = 6;
    ra[0] = W'('h3); rb[0] = W'('h5); rv[0] = 1;
    tick(); tick(); tick();
    done_cnt[0] = 0;
    rst = 1'b0;
    #1;
    chk("mid_gnt", gnt, 2'b00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_mv", m_valid, 1'b0);
    chk("mid_opa", m_op_a, '0);
    chk("mid_r0res", r0_res, '0);
    chk("mid_r1res", r1_res, '0);
    chk("mid_r0done", r0_done, 1'b0);
    mdl_reset();
    rv[1] = 1; new_op(1);
    repeat (3) tick();
    mx_fix = 0;
    rst = 1'b1;
    gq.delete();
    wait_resp(0);
    rv[0] = 0;
    chk("mid_tie", gq[0], 0);
    chk("mid_res", r0_res, W'('hf));
    wait_resp(1);
    rv[1] = 0;
    tick();

    // spurious multiplier completion while idle
    spur = 1;
    tick(); tick();
    chk("spur_r0", r0_res, W'('hf));
    chk("spur_busy", busy, 1'b0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (ph == 2 && own == p) begin
          if ($urandom % 2) new_op(p);
          else rv[p] = 0;
        end else if (!rv[p]) begin
          if ($urandom % 3 == 0) begin
            rv[p] = 1; new_op(p);
          end
        end else if (ph == 1 && own == p && ($urandom % 2)) begin
          ra[p] = W'($urandom);
        end
      end
      spur = ($urandom % 6 == 0);
      if ($urandom % 300 == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else tick();
    end
    rv[0] = 0; rv[1] = 0;
    repeat (12) tick();
    chk("end_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
